// File: rtl/arch_chk_pkg.sv
// Shared definitions for the architectural-state checker.
//   - FSM state encodings (legacy-style 3-bit constants)
//   - first-error kind encodings
//   - idx_w(): index width helper, never narrower than one bit
package arch_chk_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WAIT_STEP = 3'd1;
    localparam state_t ST_SCAN_REG  = 3'd2;
    localparam state_t ST_SCAN_MEM  = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arch_state_checker_if.sv
// Bus between the checker and its surroundings (CPU, register file,
// data memory, expected-value tables).
//
// Handshake: step is a one-cycle pulse per completed CPU cycle. In WAIT_STEP
// the checker accepts it on that same edge and raises hold combinationally,
// so the CPU must not advance on the accepting edge. hold stays high for the
// whole scan. All read ports (reg/mem/exp) return data one cycle after the
// address is presented.
//
// Modports: slave = checker side, master = CPU/bench side.
interface arch_state_checker_if
#(
    parameter int DATA_W     = 16,
    parameter int NUM_REG    = 8,
    parameter int NUM_MEM    = 8,
    parameter int NUM_CHECKS = 2,
    parameter int EXP_AW     = 8,
    parameter int ERR_W      = 8
);
    import arch_chk_pkg::*;

    localparam int RA_W  = idx_w(NUM_REG);
    localparam int MA_W  = idx_w(NUM_MEM);
    localparam int CHK_W = idx_w(NUM_CHECKS);
    localparam int IDX_W = idx_w((NUM_REG > NUM_MEM) ? NUM_REG : NUM_MEM);

    logic              start;
    logic              step;
    logic              hold;
    logic [RA_W-1:0]   reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic [MA_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [EXP_AW-1:0] exp_addr;
    logic              exp_rsel;
    logic [DATA_W-1:0] exp_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic              step_ovr;
    logic              fe_valid;
    logic [CHK_W-1:0]  fe_check;
    logic              fe_kind;
    logic [IDX_W-1:0]  fe_idx;
    logic [DATA_W-1:0] fe_got;
    logic [DATA_W-1:0] fe_exp;
    state_t            state;

    modport slave (
        input  start, step, reg_data, mem_data, exp_data,
        output hold, reg_addr, mem_addr, exp_addr, exp_rsel, busy, done, pass,
               err_cnt, step_ovr, fe_valid, fe_check, fe_kind, fe_idx,
               fe_got, fe_exp, state
    );

    modport master (
        output start, step, reg_data, mem_data, exp_data,
        input  hold, reg_addr, mem_addr, exp_addr, exp_rsel, busy, done, pass,
               err_cnt, step_ovr, fe_valid, fe_check, fe_kind, fe_idx,
               fe_got, fe_exp, state
    );

endinterface

// File: rtl/arch_chk_scan.sv
// One scan phase: walks indices 0..N-1, issues read addresses, and compares
// the returned data one cycle later.
//   en_i       phase active (N+1 cycles: N issue cycles + 1 drain cycle)
//   chk_i      current check index, selects the expected-table slice
//   got_i      observed data (1-cycle latency)
//   exp_i      expected data (1-cycle latency)
//   addr_o     entry index being issued
//   exp_addr_o chk_i*N + index
//   last_o     drain cycle of the phase
//   mm_o       mismatch on the entry issued last cycle; mm_idx_o its index
module arch_chk_scan
    import arch_chk_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int EXP_AW = 8,
    parameter int CHK_W  = 1,
    parameter int AW     = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [CHK_W-1:0]  chk_i,
    input  logic [DATA_W-1:0] got_i,
    input  logic [DATA_W-1:0] exp_i,
    output logic [AW-1:0]     addr_o,
    output logic [EXP_AW-1:0] exp_addr_o,
    output logic              last_o,
    output logic              mm_o,
    output logic [AW-1:0]     mm_idx_o
);
    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          issue;

    // cnt_q == N is the drain cycle: nothing issued, only the final compare.
    assign issue  = en_i && (cnt_q != CW'(N));
    assign last_o = en_i && (cnt_q == CW'(N));

    always_comb begin
        cnt_d = '0;
        if (issue) begin
            cnt_d = cnt_q + 1'b1;
        end
        vld_d = issue;
        idx_d = cnt_q[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign addr_o     = cnt_q[AW-1:0];
    assign exp_addr_o = EXP_AW'(chk_i) * EXP_AW'(N) + EXP_AW'(cnt_q);
    assign mm_o       = vld_q && (got_i != exp_i);
    assign mm_idx_o   = idx_q;

endmodule

// File: rtl/arch_state_checker.sv
// Architectural-state self-check engine. After each CPU cycle (step pulse)
// it stalls the CPU, scans NUM_REG registers then NUM_MEM memory words
// against expected tables, and accumulates a saturating error count plus
// the details of the first mismatch. After NUM_CHECKS checks it sits in
// DONE with pass reporting the overall verdict.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any scan)
//   bus    checker side of arch_state_checker_if (see interface header)
module arch_state_checker
    import arch_chk_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_REG    = 8,
    parameter int NUM_MEM    = 8,
    parameter int NUM_CHECKS = 2,
    parameter int EXP_AW     = 8,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arch_state_checker_if.slave   bus
);
    localparam int RA_W  = idx_w(NUM_REG);
    localparam int MA_W  = idx_w(NUM_MEM);
    localparam int CHK_W = idx_w(NUM_CHECKS);
    localparam int IDX_W = idx_w((NUM_REG > NUM_MEM) ? NUM_REG : NUM_MEM);

    state_t            state_q, state_d;
    logic [CHK_W-1:0]  chk_cnt_q, chk_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              step_ovr_q, step_ovr_d;
    logic              fe_valid_q, fe_valid_d;
    logic [CHK_W-1:0]  fe_check_q, fe_check_d;
    logic              fe_kind_q, fe_kind_d;
    logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_got_q, fe_got_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;

    logic              reg_last, reg_mm, mem_last, mem_mm;
    logic [RA_W-1:0]   reg_mm_idx;
    logic [MA_W-1:0]   mem_mm_idx;
    logic [EXP_AW-1:0] reg_exp_addr, mem_exp_addr;
    logic [CHK_W:0]    chk_next;
    logic              mm_any;

    arch_chk_scan #(.N(NUM_REG), .DATA_W(DATA_W), .EXP_AW(EXP_AW), .CHK_W(CHK_W), .AW(RA_W)) u_scan_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == ST_SCAN_REG),
        .chk_i      (chk_cnt_q),
        .got_i      (bus.reg_data),
        .exp_i      (bus.exp_data),
        .addr_o     (bus.reg_addr),
        .exp_addr_o (reg_exp_addr),
        .last_o     (reg_last),
        .mm_o       (reg_mm),
        .mm_idx_o   (reg_mm_idx)
    );

    arch_chk_scan #(.N(NUM_MEM), .DATA_W(DATA_W), .EXP_AW(EXP_AW), .CHK_W(CHK_W), .AW(MA_W)) u_scan_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == ST_SCAN_MEM),
        .chk_i      (chk_cnt_q),
        .got_i      (bus.mem_data),
        .exp_i      (bus.exp_data),
        .addr_o     (bus.mem_addr),
        .exp_addr_o (mem_exp_addr),
        .last_o     (mem_last),
        .mm_o       (mem_mm),
        .mm_idx_o   (mem_mm_idx)
    );

    // Phases never overlap, so at most one scanner reports a mismatch.
    assign mm_any   = reg_mm | mem_mm;
    assign chk_next = {1'b0, chk_cnt_q} + 1'b1;

    always_comb begin
        state_d    = state_q;
        chk_cnt_d  = chk_cnt_q;
        err_cnt_d  = err_cnt_q;
        step_ovr_d = step_ovr_q;
        fe_valid_d = fe_valid_q;
        fe_check_d = fe_check_q;
        fe_kind_d  = fe_kind_q;
        fe_idx_d   = fe_idx_q;
        fe_got_d   = fe_got_q;
        fe_exp_d   = fe_exp_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_WAIT_STEP;
                    chk_cnt_d  = '0;
                    err_cnt_d  = '0;
                    step_ovr_d = 1'b0;
                    fe_valid_d = 1'b0;
                    fe_check_d = '0;
                    fe_kind_d  = 1'b0;
                    fe_idx_d   = '0;
                    fe_got_d   = '0;
                    fe_exp_d   = '0;
                end
            end
            ST_WAIT_STEP: begin
                if (bus.step) begin
                    state_d = ST_SCAN_REG;
                end
            end
            ST_SCAN_REG: begin
                if (reg_last) begin
                    state_d = ST_SCAN_MEM;
                end
            end
            ST_SCAN_MEM: begin
                if (mem_last) begin
                    if (chk_next == (CHK_W+1)'(NUM_CHECKS)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_WAIT_STEP;
                        chk_cnt_d = chk_next[CHK_W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q == ST_SCAN_REG || state_q == ST_SCAN_MEM) && bus.step) begin
            step_ovr_d = 1'b1;
        end

        if (mm_any) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!fe_valid_q) begin
                fe_valid_d = 1'b1;
                fe_check_d = chk_cnt_q;
                fe_kind_d  = mem_mm ? KIND_MEM : KIND_REG;
                fe_idx_d   = mem_mm ? IDX_W'(mem_mm_idx) : IDX_W'(reg_mm_idx);
                fe_got_d   = mem_mm ? bus.mem_data : bus.reg_data;
                fe_exp_d   = bus.exp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            step_ovr_q <= 1'b0;
            fe_valid_q <= 1'b0;
            fe_check_q <= '0;
            fe_kind_q  <= 1'b0;
            fe_idx_q   <= '0;
            fe_got_q   <= '0;
            fe_exp_q   <= '0;
        end else begin
            state_q    <= state_d;
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            step_ovr_q <= step_ovr_d;
            fe_valid_q <= fe_valid_d;
            fe_check_q <= fe_check_d;
            fe_kind_q  <= fe_kind_d;
            fe_idx_q   <= fe_idx_d;
            fe_got_q   <= fe_got_d;
            fe_exp_q   <= fe_exp_d;
        end
    end

    // Shared expected-table port: memory slice only while scanning memory.
    assign bus.exp_rsel = (state_q == ST_SCAN_MEM);
    assign bus.exp_addr = (state_q == ST_SCAN_MEM) ? mem_exp_addr : reg_exp_addr;

    assign bus.hold     = (state_q == ST_SCAN_REG) || (state_q == ST_SCAN_MEM) ||
                          ((state_q == ST_WAIT_STEP) && bus.step);
    assign bus.busy     = (state_q == ST_WAIT_STEP) || (state_q == ST_SCAN_REG) ||
                          (state_q == ST_SCAN_MEM);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.pass     = (state_q == ST_DONE) && (err_cnt_q == '0) && !step_ovr_q;
    assign bus.err_cnt  = err_cnt_q;
    assign bus.step_ovr = step_ovr_q;
    assign bus.fe_valid = fe_valid_q;
    assign bus.fe_check = fe_check_q;
    assign bus.fe_kind  = fe_kind_q;
    assign bus.fe_idx   = fe_idx_q;
    assign bus.fe_got   = fe_got_q;
    assign bus.fe_exp   = fe_exp_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_arch_state_checker.sv
module tb_arch_state_checker;
    import arch_chk_pkg::*;

    localparam int DATA_W     = 16;
    localparam int NUM_REG    = 8;
    localparam int NUM_MEM    = 8;
    localparam int NUM_CHECKS = 2;
    localparam int EXP_AW     = 8;
    localparam int ERR_W      = 3;
    localparam int SCAN_HOLD  = NUM_REG + NUM_MEM + 2;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] reg_arr [NUM_REG];
    logic [DATA_W-1:0] mem_arr [NUM_MEM];
    logic [DATA_W-1:0] exp_reg_tab [2**EXP_AW];
    logic [DATA_W-1:0] exp_mem_tab [2**EXP_AW];

    arch_state_checker_if #(
        .DATA_W(DATA_W), .NUM_REG(NUM_REG), .NUM_MEM(NUM_MEM),
        .NUM_CHECKS(NUM_CHECKS), .EXP_AW(EXP_AW), .ERR_W(ERR_W)
    ) bus ();

    arch_state_checker #(
        .DATA_W(DATA_W), .NUM_REG(NUM_REG), .NUM_MEM(NUM_MEM),
        .NUM_CHECKS(NUM_CHECKS), .EXP_AW(EXP_AW), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency memory models
    always @(posedge clk) begin
        bus.reg_data <= reg_arr[bus.reg_addr];
        bus.mem_data <= mem_arr[bus.mem_addr];
        bus.exp_data <= bus.exp_rsel ? exp_mem_tab[bus.exp_addr] : exp_reg_tab[bus.exp_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_tables();
        for (int i = 0; i < NUM_REG; i++) reg_arr[i] = DATA_W'(i + 1);
        for (int i = 0; i < NUM_MEM; i++) mem_arr[i] = DATA_W'(i + 1);
        for (int a = 0; a < 2**EXP_AW; a++) begin
            exp_reg_tab[a] = DATA_W'((a % NUM_REG) + 1);
            exp_mem_tab[a] = DATA_W'((a % NUM_MEM) + 1);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // inj: 0 = plain step, 1 = extra step in SCAN_MEM, 2 = start during scan
    task automatic do_step(input int inj, output int hcnt);
        bit pulsed;
        pulsed = 1'b0;
        @(negedge clk);
        bus.step = 1'b1;
        #1;
        check("hold_on_accept", 32'(bus.hold), 32'd1);
        @(negedge clk);
        bus.step = 1'b0;
        hcnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.hold) break;
            hcnt++;
            if (inj == 1 && !pulsed && bus.state == ST_SCAN_MEM) begin
                bus.step = 1'b1;
                pulsed   = 1'b1;
            end
            if (inj == 2 && !pulsed) begin
                bus.start = 1'b1;
                pulsed    = 1'b1;
            end
            @(negedge clk);
            bus.step  = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int hc;
        int k;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        load_tables();
        repeat (2) @(negedge clk);

        // reset state
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        check("rst_hold", 32'(bus.hold), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);
        check("rst_fe_valid", 32'(bus.fe_valid), 32'd0);
        rst_n = 1'b1;

        // step while idle is ignored
        @(negedge clk);
        bus.step = 1'b1;
        #1 check("idle_step_hold", 32'(bus.hold), 32'd0);
        @(negedge clk);
        bus.step = 1'b0;
        check("idle_step_state", 32'(bus.state), 32'(ST_IDLE));

        // A: matching tables -> PASS
        pulse_start();
        check("a_state_wait", 32'(bus.state), 32'(ST_WAIT_STEP));
        check("a_busy", 32'(bus.busy), 32'd1);
        do_step(0, hc);
        check("a_hold_cnt0", 32'(hc), 32'(SCAN_HOLD));
        check("a_mid_state", 32'(bus.state), 32'(ST_WAIT_STEP));
        check("a_mid_done", 32'(bus.done), 32'd0);
        do_step(0, hc);
        check("a_hold_cnt1", 32'(hc), 32'(SCAN_HOLD));
        check("a_done", 32'(bus.done), 32'd1);
        check("a_pass", 32'(bus.pass), 32'd1);
        check("a_err", 32'(bus.err_cnt), 32'd0);
        check("a_busy_done", 32'(bus.busy), 32'd0);

        // B: check 1, register 3 expected 0x00FF, observed 0x0004
        exp_reg_tab[1*NUM_REG + 3] = 16'h00FF;
        pulse_start();
        check("b_done_cleared", 32'(bus.done), 32'd0);
        do_step(0, hc);
        check("b_err_chk0", 32'(bus.err_cnt), 32'd0);
        do_step(0, hc);
        check("b_done", 32'(bus.done), 32'd1);
        check("b_pass", 32'(bus.pass), 32'd0);
        check("b_err", 32'(bus.err_cnt), 32'd1);
        check("b_fe_valid", 32'(bus.fe_valid), 32'd1);
        check("b_fe_check", 32'(bus.fe_check), 32'd1);
        check("b_fe_kind", 32'(bus.fe_kind), 32'd0);
        check("b_fe_idx", 32'(bus.fe_idx), 32'd3);
        check("b_fe_got", 32'(bus.fe_got), 32'h0004);
        check("b_fe_exp", 32'(bus.fe_exp), 32'h00FF);
        load_tables();

        // C: every memory entry wrong -> counter saturates at 7
        for (int a = 0; a < 2**EXP_AW; a++) exp_mem_tab[a] = DATA_W'(16'hA000 + a);
        pulse_start();
        do_step(0, hc);
        check("c_err_sat0", 32'(bus.err_cnt), 32'd7);
        do_step(0, hc);
        check("c_err_sat1", 32'(bus.err_cnt), 32'd7);
        check("c_pass", 32'(bus.pass), 32'd0);
        check("c_fe_check", 32'(bus.fe_check), 32'd0);
        check("c_fe_kind", 32'(bus.fe_kind), 32'd1);
        check("c_fe_idx", 32'(bus.fe_idx), 32'd0);
        check("c_fe_got", 32'(bus.fe_got), 32'h0001);
        check("c_fe_exp", 32'(bus.fe_exp), 32'hA000);
        load_tables();

        // START in DONE clears counters
        pulse_start();
        check("clr_state", 32'(bus.state), 32'(ST_WAIT_STEP));
        check("clr_err", 32'(bus.err_cnt), 32'd0);
        check("clr_fe_valid", 32'(bus.fe_valid), 32'd0);
        check("clr_fe_got", 32'(bus.fe_got), 32'd0);

        // D: step during SCAN_MEM -> overrun, no extra check
        do_step(1, hc);
        check("d_hold_cnt", 32'(hc), 32'(SCAN_HOLD));
        check("d_state", 32'(bus.state), 32'(ST_WAIT_STEP));
        check("d_step_ovr", 32'(bus.step_ovr), 32'd1);
        do_step(0, hc);
        check("d_done", 32'(bus.done), 32'd1);
        check("d_pass", 32'(bus.pass), 32'd0);
        check("d_err", 32'(bus.err_cnt), 32'd0);

        // E: reset mid SCAN_REG at index 4
        exp_reg_tab[0] = 16'h1234;
        pulse_start();
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        k = 0;
        while (!(bus.state == ST_SCAN_REG && bus.reg_addr == 3'd4) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("e_reach_idx4", 32'(k < 50), 32'd1);
        check("e_err_pre", 32'(bus.err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("e_state", 32'(bus.state), 32'(ST_IDLE));
        check("e_hold", 32'(bus.hold), 32'd0);
        check("e_busy", 32'(bus.busy), 32'd0);
        check("e_err", 32'(bus.err_cnt), 32'd0);
        check("e_fe_valid", 32'(bus.fe_valid), 32'd0);
        check("e_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("e_exp_addr", 32'(bus.exp_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_tables();
        pulse_start();
        do_step(0, hc);
        do_step(0, hc);
        check("e_rerun_done", 32'(bus.done), 32'd1);
        check("e_rerun_pass", 32'(bus.pass), 32'd1);

        // F: START while busy is ignored
        pulse_start();
        do_step(2, hc);
        check("f_state", 32'(bus.state), 32'(ST_WAIT_STEP));
        check("f_done_mid", 32'(bus.done), 32'd0);
        do_step(0, hc);
        check("f_done", 32'(bus.done), 32'd1);
        check("f_pass", 32'(bus.pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
